// File: rtl/dds_phase_accum.sv
// Phase accumulator and half-wave LUT address generator for the DDS chain,
// with fixed-frequency run and a dwell-stepped linear FTW sweep.
module dds_phase_accum #(
    parameter int ACC_W   = 32,
    parameter int LUT_LAT = 1,
    parameter int DWELL   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             phase_clr,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_load,
    input  logic             sweep_start,
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] sweep_stop,
    output logic [8:0]       lut_addr,
    output logic [9:0]       phase_out,
    output logic             wrap,
    output logic             busy,
    output logic             sweep_done,
    output logic [ACC_W-1:0] ftw_active
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SWEEP
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [ACC_W-1:0] stop_q, stop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             busy_q;
    logic             done_q, done_d;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   sweep_sum;
    logic             advance;

    assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_q};
    // One extra bit so a step that overflows the FTW still terminates the sweep.
    assign sweep_sum = {1'b0, ftw_q} + {1'b0, step_q};
    assign advance   = en && (state_q != S_IDLE);

    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (phase_clr) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_q;
        step_d  = step_q;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ftw_load) begin
                    ftw_d = ftw_in;
                end
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ftw_load) begin
                    ftw_d = ftw_in;
                end
                if (!en) begin
                    state_d = S_IDLE;
                end else if (sweep_start && !ftw_load) begin
                    if (sweep_stop > ftw_q) begin
                        step_d  = sweep_step;
                        stop_d  = sweep_stop;
                        cnt_d   = DWELL_RELOAD;
                        state_d = S_SWEEP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (sweep_sum >= {1'b0, stop_q}) begin
                        ftw_d   = stop_q;
                        done_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        ftw_d = sweep_sum[ACC_W-1:0];
                        cnt_d = DWELL_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ftw_q   <= '0;
            step_q  <= '0;
            stop_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d == S_SWEEP);
            done_q  <= done_d;
        end
    end

    assign lut_addr   = acc_q[ACC_W-2 -: 9];
    assign wrap       = wrap_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign ftw_active = ftw_q;

    // Phase delay line aligns the fold-stage phase with LUT read data.
    genvar gi;
    generate
        if (LUT_LAT == 0) begin : g_no_dly
            assign phase_out = acc_q[ACC_W-1 -: 10];
        end else begin : g_dly
            logic [9:0] dly_q [LUT_LAT];
            for (gi = 0; gi < LUT_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dly_q[gi] <= '0;
                        end else begin
                            dly_q[gi] <= acc_q[ACC_W-1 -: 10];
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dly_q[gi] <= '0;
                        end else begin
                            dly_q[gi] <= dly_q[gi-1];
                        end
                    end
                end
            end
            assign phase_out = dly_q[LUT_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum: directed scenarios then random
// stimulus, every clock compared against a behavioural phase/FTW model.
module tb_dds_phase_accum;

    localparam int ACC_W   = 32;
    localparam int LUT_LAT = 1;
    localparam int DWELL   = 16;
    localparam longint unsigned MOD = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst, en, phase_clr, ftw_load, sweep_start;
    logic [ACC_W-1:0] ftw_in, sweep_step, sweep_stop;
    logic [8:0]       lut_addr;
    logic [9:0]       phase_out;
    logic             wrap, busy, sweep_done;
    logic [ACC_W-1:0] ftw_active;

    always #50 clk = ~clk;

    dds_phase_accum #(.ACC_W(ACC_W), .LUT_LAT(LUT_LAT), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .phase_clr  (phase_clr),
        .ftw_in     (ftw_in),
        .ftw_load   (ftw_load),
        .sweep_start(sweep_start),
        .sweep_step (sweep_step),
        .sweep_stop (sweep_stop),
        .lut_addr   (lut_addr),
        .phase_out  (phase_out),
        .wrap       (wrap),
        .busy       (busy),
        .sweep_done (sweep_done),
        .ftw_active (ftw_active)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: phase as an integer, sweep as "clocks left until next step".
    longint unsigned m_acc, m_ftw, m_step, m_stop;
    bit              m_run, m_sweep, m_wrap, m_done;
    int              m_left;
    int unsigned     m_phase;
    int unsigned     ph_q[$];

    function automatic int unsigned top10(input longint unsigned a);
        return int'((a >> (ACC_W - 10)) & 64'd1023);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_step = 0; m_stop = 0;
        m_run = 0; m_sweep = 0; m_wrap = 0; m_done = 0;
        m_left = 0; m_phase = 0;
        ph_q.delete();
        for (int i = 0; i < LUT_LAT - 1; i++) ph_q.push_back(0);
    endtask

    task automatic model_step();
        longint unsigned s;
        int unsigned old_top;
        bit moving;
        if (rst) begin
            model_reset();
            return;
        end
        old_top = top10(m_acc);
        moving  = (m_run || m_sweep) && en;
        m_done  = 0;
        if (phase_clr) begin
            m_acc = 0; m_wrap = 0;
        end else if (moving) begin
            s = m_acc + m_ftw;
            m_wrap = (s >= MOD);
            m_acc = s % MOD;
        end else begin
            m_wrap = 0;
        end
        if (LUT_LAT == 0) begin
            m_phase = top10(m_acc);
        end else begin
            ph_q.push_back(old_top);
            m_phase = ph_q.pop_front();
        end
        if (m_sweep) begin
            if (!en) begin
                m_sweep = 0; m_run = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    s = m_ftw + m_step;
                    if (s >= m_stop) begin
                        m_ftw = m_stop; m_done = 1; m_sweep = 0;
                    end else begin
                        m_ftw = s; m_left = DWELL;
                    end
                end
            end
        end else if (m_run) begin
            if (ftw_load) begin
                m_ftw = ftw_in;
            end
            if (!en) begin
                m_run = 0;
            end else if (sweep_start && !ftw_load) begin
                if (longint'(sweep_stop) > m_ftw) begin
                    m_step = sweep_step; m_stop = sweep_stop;
                    m_left = DWELL; m_sweep = 1;
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            if (ftw_load) m_ftw = ftw_in;
            if (en) m_run = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("lut_addr", lut_addr, top10(m_acc) & 511);
        check_eq("phase_out", phase_out, m_phase);
        check_eq("wrap", wrap, m_wrap);
        check_eq("busy", busy, m_sweep);
        check_eq("sweep_done", sweep_done, m_done);
        check_eq("ftw_active", ftw_active, m_ftw);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int wraps, busy_cnt, done_cnt;

    initial begin
        rst = 1; en = 0; phase_clr = 0; ftw_load = 0; sweep_start = 0;
        ftw_in = '0; sweep_step = '0; sweep_stop = '0;
        model_reset();
        repeat (3) tick();
        rst = 0;
        tick();

        // Fixed-frequency run: one wrap per 1024 advances
        ftw_in = 32'h0040_0000; ftw_load = 1; tick(); ftw_load = 0;
        en = 1;
        wraps = 0;
        repeat (1030) begin
            tick();
            if (wrap) wraps++;
        end
        check_eq("wrap_count", wraps, 1);

        // Enable drop: phase holds
        en = 0; repeat (5) tick(); en = 1; repeat (10) tick();

        // Phase clear mid-run
        repeat (7) tick();
        phase_clr = 1; tick(); phase_clr = 0;
        check_eq("clr_lut_addr", lut_addr, 0);
        tick();
        check_eq("clr_phase_out", phase_out, 0);

        // Directed sweep 0x40_0000 -> 0x100_0000 in 0x40_0000 steps
        sweep_step = 32'h0040_0000; sweep_stop = 32'h0100_0000;
        sweep_start = 1; tick(); sweep_start = 0;
        busy_cnt = int'(busy); done_cnt = 0;
        repeat (60) begin
            tick();
            busy_cnt += int'(busy);
            done_cnt += int'(sweep_done);
        end
        check_eq("sweep_busy_cycles", busy_cnt, 48);
        check_eq("sweep_done_count", done_cnt, 1);
        check_eq("sweep_final_ftw", ftw_active, 32'h0100_0000);

        // Stop below current FTW: immediate done, no sweep
        sweep_stop = 32'h0010_0000; sweep_start = 1; tick(); sweep_start = 0;
        check_eq("below_done", sweep_done, 1);
        check_eq("below_busy", busy, 0);
        tick();

        // Sweep with ignored load, then abort by en=0
        sweep_step = 32'h0010_0000; sweep_stop = 32'h0200_0000;
        sweep_start = 1; tick(); sweep_start = 0;
        repeat (20) tick();
        ftw_in = 32'h0000_DEAD; ftw_load = 1; tick(); ftw_load = 0;
        en = 0; tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", sweep_done, 0);
        check_eq("abort_ftw", ftw_active, 32'h0110_0000);
        en = 1; repeat (4) tick();

        // Reset mid-sweep
        sweep_start = 1; tick(); sweep_start = 0;
        repeat (10) tick();
        rst = 1; tick();
        check_eq("rst_ftw", ftw_active, 0);
        check_eq("rst_busy", busy, 0);
        rst = 0; repeat (3) tick();

        // Random stimulus
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom_range(0, 999) == 0);
            en          = ($urandom_range(0, 29) != 0);
            phase_clr   = ($urandom_range(0, 99) == 0);
            ftw_load    = ($urandom_range(0, 49) == 0);
            sweep_start = ($urandom_range(0, 39) == 0);
            ftw_in      = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0200_0000);
            sweep_step  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0080_0000);
            sweep_stop  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0400_0000);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
- Phase accumulator and LUT address generator at the head of the DDS chain.
- Advances an ACC_W-bit phase by an active frequency tuning word (FTW) every clock.
- Drives the half-wave LUT address, and drives the 10-bit phase to the output-fold stage, delayed to line up with the LUT read data.
- Supports fixed-frequency run and a linear frequency sweep (chirp) under a small state machine.

Parameters:
- ACC_W, 32, accumulator and FTW width (≥ 12).
- LUT_LAT, 1, LUT read latency in clocks; phase_out delay (0..4).
- DWELL, 16, clocks per sweep step (≥ 1).

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes the accumulator.
- phase_clr  in  1  single-cycle pulse; zero the accumulator.
- ftw_in  in  ACC_W  new tuning word.
- ftw_load  in  1  single-cycle strobe; capture ftw_in.
- sweep_start  in  1  single-cycle strobe; begin a sweep.
- sweep_step  in  ACC_W  FTW increment per dwell period; captured at sweep_start.
- sweep_stop  in  ACC_W  final FTW; captured at sweep_start.
- lut_addr  out  9  acc[ACC_W-2 -: 9]; goes to the LUT address.
- phase_out  out  10  acc[ACC_W-1 -: 10]; delayed LUT_LAT clocks; goes to the fold stage phase input.
- wrap  out  1  one-cycle pulse on accumulator carry-out; undelayed.
- busy  out  1  high while in SWEEP.
- sweep_done  out  1  one-cycle pulse at sweep completion.
- ftw_active  out  ACC_W  FTW currently in use.

Behaviour:
- Reset:
  - state = IDLE.
  - acc, ftw_active, dwell counter, phase delay line: all 0.
  - lut_addr, phase_out, wrap, busy, sweep_done: all 0.
- All outputs are registered.
- Accumulator:
  - In RUN or SWEEP: acc <= acc + ftw_active, modulo 2^ACC_W.
  - wrap is set on the same edge when the add carries out.
  - In IDLE: acc holds and wrap = 0.
- lut_addr reflects the new acc on the same edge.
- phase_out delay:
  - phase_out is the top 10 bits of acc passed through LUT_LAT register stages.
  - With LUT_LAT = 0, phase_out shares lut_addr's timing.
  - The delay line shifts every clock, including in IDLE.
- phase_clr:
  - acc <= 0 on that edge, overriding the add. wrap = 0.
  - ftw_active and state are unchanged.
  - The delay line flushes naturally over LUT_LAT clocks.
- ftw_load:
  - Accepted in IDLE or RUN: ftw_active <= ftw_in on that edge.
  - The add on that edge uses the old FTW.
  - Ignored in SWEEP.
- Priority: rst > phase_clr > ftw_load > sweep_start.
  - phase_clr together with ftw_load: both take effect.
  - ftw_load together with sweep_start: load is applied, sweep_start is ignored.
- State machine:
  - IDLE:
    - en = 1 → RUN.
    - sweep_start is ignored.
  - RUN:
    - en = 0 → IDLE.
    - sweep_start with sweep_stop > ftw_active: capture step and stop, dwell counter = DWELL-1, busy = 1, go to SWEEP.
    - sweep_start with sweep_stop ≤ ftw_active: stay in RUN, pulse sweep_done on the next clock, ftw_active unchanged.
  - SWEEP:
    - Dwell counter decrements every clock.
    - At 0: sum = ftw_active + step, computed at ACC_W+1 bits.
    - If sum ≥ stop (including overflow): ftw_active <= stop, pulse sweep_done, busy = 0, go to RUN.
    - Otherwise: ftw_active <= sum and reload the counter.
    - step = 0 never terminates; only en = 0 or rst exits.
    - en = 0: abort to IDLE. ftw_active keeps its current value, no sweep_done, busy = 0.
- rst mid-sweep returns everything to the reset values.

Test Plan:
- ACC_W=32, LUT_LAT=1: ftw_load 0x0040_0000 then en=1.
  - lut_addr steps 0,1,2,…,511,0 per clock.
  - phase_out lags lut_addr by exactly 1 clock and reaches 512..1023 on the second half.
  - wrap pulses once every 1024 clocks.
- Running at FTW 0x0040_0000: drop en for 5 clocks. Phase holds, no wrap, and phase resumes from the same value when en returns.
- phase_clr mid-run: lut_addr = 0 on the next clock; phase_out = 0 one clock later.
- FTW 0x0040_0000, DWELL=16: sweep_start with step 0x0040_0000, stop 0x0100_0000.
  - ftw_active goes 0x0080_0000 → 0x00C0_0000 → 0x0100_0000, at 16-clock intervals.
  - sweep_done pulses on the final update.
  - busy is high for 48 clocks.
- sweep_stop 0x0010_0000 below the current FTW: no SWEEP entry and busy stays 0. sweep_done pulses one clock later.
- Mid-sweep, ftw_load is ignored. Then en=0 gives IDLE with the partial FTW held and no done pulse. Separately, rst mid-sweep zeros all outputs.
